// File: rtl/gshare_predictor.sv
// Two-bit-counter branch predictor with speculative/architectural global history.
// Define GSHARE_XOR_HASH_EN for XOR (gshare) indexing; default is gselect concatenation.
module gshare_predictor #(
  parameter int         HIST_LEN = 3,
  parameter int         IDX_LEN  = 7,
  parameter logic [1:0] CNT_INIT = 2'b10,
  parameter int         ADDR_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               if_valid,
  input  logic [ADDR_W-1:0]  if_pc,
  input  logic [31:0]        inst,
  output logic               pred_jump_or_not,
  output logic [ADDR_W-1:0]  pred_pc,
  output logic [IDX_LEN-1:0] pred_idx,
  input  logic               ex_valid,
  input  logic [IDX_LEN-1:0] ex_idx,
  input  logic               ex_jump_or_not,
  input  logic               ex_mispredict,
  output logic [31:0]        stat_branches,
  output logic [31:0]        stat_mispredicts
);

  localparam int DEPTH = 1 << IDX_LEN;

  logic [1:0]          r_table [DEPTH];
  logic [HIST_LEN-1:0] r_arch_hist;
  logic [HIST_LEN-1:0] r_spec_hist;
  logic [31:0]         r_stat_br;
  logic [31:0]         r_stat_mis;

  logic                w_is_jal;
  logic                w_is_br;
  logic [31:0]         w_j_imm;
  logic [31:0]         w_b_imm;
  logic [ADDR_W-1:0]   w_j_tgt;
  logic [ADDR_W-1:0]   w_b_tgt;
  logic [IDX_LEN-1:0]  w_idx;
  logic [1:0]          w_ctr;
  logic                w_br_taken;
  logic                w_taken;
  logic [HIST_LEN-1:0] w_arch_next;
  logic [HIST_LEN-1:0] w_spec_pred;

  assign w_is_jal = (inst[6:0] == 7'b1101111);
  assign w_is_br  = (inst[6:0] == 7'b1100011);

  assign w_j_imm = {{11{inst[31]}}, inst[31], inst[19:12],
                    inst[20], inst[30:21], 1'b0};
  assign w_b_imm = {{19{inst[31]}}, inst[31], inst[7],
                    inst[30:25], inst[11:8], 1'b0};

  assign w_j_tgt = if_pc + ADDR_W'($signed(w_j_imm));
  assign w_b_tgt = if_pc + ADDR_W'($signed(w_b_imm));

`ifdef GSHARE_XOR_HASH_EN
  assign w_idx = if_pc[IDX_LEN+1:2] ^ IDX_LEN'(r_spec_hist);
`else
  assign w_idx = {r_spec_hist, if_pc[IDX_LEN-HIST_LEN+1:2]};
`endif

  // Reads see the pre-update counter; a same-cycle resolution is not bypassed.
  assign w_ctr      = r_table[w_idx];
  assign w_br_taken = w_is_br & w_ctr[1];
  assign w_taken    = w_is_jal | w_br_taken;

  always_comb begin
    pred_jump_or_not = 1'b0;
    pred_pc          = '0;
    pred_idx         = '0;
    if (!rst) begin
      pred_jump_or_not = w_taken;
      pred_idx         = w_idx;
      if (w_is_jal)
        pred_pc = w_j_tgt;
      else if (w_br_taken)
        pred_pc = w_b_tgt;
    end
  end

  // Truncating casts keep the shift legal for HIST_LEN == 1.
  assign w_arch_next = HIST_LEN'({r_arch_hist, ex_jump_or_not});
  assign w_spec_pred = HIST_LEN'({r_spec_hist, w_taken});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        r_table[i] <= CNT_INIT;
    end else if (rdy && ex_valid) begin
      if (ex_jump_or_not && r_table[ex_idx] != 2'b11)
        r_table[ex_idx] <= r_table[ex_idx] + 2'd1;
      else if (!ex_jump_or_not && r_table[ex_idx] != 2'b00)
        r_table[ex_idx] <= r_table[ex_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_arch_hist <= '0;
    end else if (rdy && ex_valid) begin
      r_arch_hist <= w_arch_next;
    end
  end

  // Repair wins: the same-cycle fetch is flushed, so its guess is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_spec_hist <= '0;
    end else if (rdy) begin
      if (ex_valid && ex_mispredict)
        r_spec_hist <= w_arch_next;
      else if (if_valid && w_is_br)
        r_spec_hist <= w_spec_pred;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_br  <= '0;
      r_stat_mis <= '0;
    end else if (rdy && ex_valid) begin
      r_stat_br <= r_stat_br + 32'd1;
      if (ex_mispredict)
        r_stat_mis <= r_stat_mis + 32'd1;
    end
  end

  assign stat_branches    = r_stat_br;
  assign stat_mispredicts = r_stat_mis;

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed, table-driven bench for gshare_predictor.
module tb_gshare_predictor;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] JAL = 32'h1000_006F;
  localparam logic [31:0] BM8 = 32'hFE00_0CE3;
  localparam logic [31:0] B16 = 32'h0000_0863;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] inst;
  logic        pred_jump_or_not;
  logic [31:0] pred_pc;
  logic [6:0]  pred_idx;
  logic        ex_valid;
  logic [6:0]  ex_idx;
  logic        ex_jump_or_not;
  logic        ex_mispredict;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  int n_err = 0;
  int n_chk = 0;

  gshare_predictor dut (
    .clk              (clk),
    .rst              (rst),
    .rdy              (rdy),
    .if_valid         (if_valid),
    .if_pc            (if_pc),
    .inst             (inst),
    .pred_jump_or_not (pred_jump_or_not),
    .pred_pc          (pred_pc),
    .pred_idx         (pred_idx),
    .ex_valid         (ex_valid),
    .ex_idx           (ex_idx),
    .ex_jump_or_not   (ex_jump_or_not),
    .ex_mispredict    (ex_mispredict),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        exv;
    logic [6:0]  exi;
    logic        exj;
    logic        exm;
    logic        tk;
    logic [31:0] ppc;
    logic [2:0]  hist;
  } vec_t;

  vec_t vt [18];

  function automatic logic [6:0] idx_of(input logic [2:0] h,
                                        input logic [31:0] pc);
`ifdef GSHARE_XOR_HASH_EN
    return pc[8:2] ^ {4'b0000, h};
`else
    return {h, pc[5:2]};
`endif
  endfunction

  function automatic vec_t mk(
    input logic iv, input logic [31:0] pc, input logic [31:0] ins,
    input logic exv, input logic [6:0] exi, input logic exj,
    input logic exm, input logic tk, input logic [31:0] ppc,
    input logic [2:0] hist);
    vec_t v;
    v.iv = iv; v.pc = pc; v.ins = ins;
    v.exv = exv; v.exi = exi; v.exj = exj; v.exm = exm;
    v.tk = tk; v.ppc = ppc; v.hist = hist;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] pc,
                       input logic [31:0] ins, input logic exv,
                       input logic [6:0] exi, input logic exj,
                       input logic exm);
    if_valid       = iv;
    if_pc          = pc;
    inst           = ins;
    ex_valid       = exv;
    ex_idx         = exi;
    ex_jump_or_not = exj;
    ex_mispredict  = exm;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    drive(0, 32'h1000, JAL, 0, 7'd0, 0, 0);
    #2;
    chk("rst_taken", {31'd0, pred_jump_or_not}, 32'd0);
    chk("rst_pc", pred_pc, 32'd0);
    chk("rst_idx", {25'd0, pred_idx}, 32'd0);
    chk("rst_br", stat_branches, 32'd0);
    chk("rst_mis", stat_mispredicts, 32'd0);
    step();
    step();
    rst = 1'b0;

    vt[0]  = mk(1, 32'h1000, JAL, 0, 7'd0,  0, 0, 1, 32'h1100, 3'b000);
    vt[1]  = mk(0, 32'h1000, BM8, 0, 7'd0,  0, 0, 1, 32'h0FF8, 3'b000);
    vt[2]  = mk(0, 32'h14,   NOP, 1, 7'd5,  0, 0, 0, 32'h0,    3'b000);
    vt[3]  = mk(0, 32'h14,   B16, 1, 7'd5,  0, 0, 0, 32'h0,    3'b000);
    vt[4]  = mk(0, 32'h14,   B16, 1, 7'd5,  0, 0, 0, 32'h0,    3'b000);
    vt[5]  = mk(0, 32'h14,   B16, 0, 7'd0,  0, 0, 0, 32'h0,    3'b000);
    vt[6]  = mk(0, 32'h0,    NOP, 1, 7'd0,  1, 0, 0, 32'h0,    3'b000);
    vt[7]  = mk(0, 32'h0,    NOP, 1, 7'd0,  0, 0, 0, 32'h0,    3'b000);
    vt[8]  = mk(1, 32'h20,   B16, 0, 7'd0,  0, 0, 1, 32'h30,   3'b000);
    vt[9]  = mk(1, 32'h20,   B16, 0, 7'd0,  0, 0, 1, 32'h30,   3'b001);
    vt[10] = mk(1, 32'h20,   B16, 0, 7'd0,  0, 0, 1, 32'h30,   3'b011);
    vt[11] = mk(1, 32'h20,   B16, 0, 7'd0,  0, 0, 1, 32'h30,   3'b111);
    vt[12] = mk(0, 32'h20,   NOP, 1, 7'd0,  0, 1, 0, 32'h0,    3'b111);
    vt[13] = mk(1, 32'h20,   B16, 1, idx_of(3'b100, 32'h20),
                0, 1, 1, 32'h30, 3'b100);
    vt[14] = mk(0, 32'h0,    NOP, 1, 7'h7F, 1, 0, 0, 32'h0,    3'b000);
    vt[15] = mk(0, 32'h0,    NOP, 1, 7'h7F, 0, 0, 0, 32'h0,    3'b000);
    vt[16] = mk(0, 32'h0,    NOP, 1, 7'h7F, 0, 1, 0, 32'h0,    3'b000);
    vt[17] = mk(0, 32'h20,   B16, 0, 7'd0,  0, 0, 0, 32'h0,    3'b100);

    for (int i = 0; i < 18; i++) begin
      drive(vt[i].iv, vt[i].pc, vt[i].ins, vt[i].exv,
            vt[i].exi, vt[i].exj, vt[i].exm);
      #2;
      chk($sformatf("v%0d_taken", i), {31'd0, pred_jump_or_not},
          {31'd0, vt[i].tk});
      chk($sformatf("v%0d_pc", i), pred_pc, vt[i].ppc);
      chk($sformatf("v%0d_idx", i), {25'd0, pred_idx},
          {25'd0, idx_of(vt[i].hist, vt[i].pc)});
      step();
    end
    drive(0, 32'h0, NOP, 0, 7'd0, 0, 0);
    #1;
    chk("stat_br10", stat_branches, 32'd10);
    chk("stat_mis3", stat_mispredicts, 32'd3);

    // Stall: nothing may move while rdy is low.
    step();
    rdy = 1'b0;
    drive(1, 32'h20, B16, 1, idx_of(3'b100, 32'h20), 1, 1);
    #2;
    chk("stall_idx", {25'd0, pred_idx},
        {25'd0, idx_of(3'b100, 32'h20)});
    chk("stall_taken", {31'd0, pred_jump_or_not}, 32'd0);
    step();
    rdy = 1'b1;
    drive(0, 32'h20, B16, 0, 7'd0, 0, 0);
    #2;
    chk("hold_idx", {25'd0, pred_idx},
        {25'd0, idx_of(3'b100, 32'h20)});
    chk("hold_taken", {31'd0, pred_jump_or_not}, 32'd0);
    chk("hold_br", stat_branches, 32'd10);
    chk("hold_mis", stat_mispredicts, 32'd3);

    // Drive arch_hist to x10, then mispredict taken -> spec_hist 101.
    step();
    drive(0, 32'h0, NOP, 1, 7'h7F, 1, 0);
    step();
    drive(0, 32'h0, NOP, 1, 7'h7F, 0, 0);
    step();
    drive(0, 32'h0, NOP, 1, 7'h7F, 1, 1);
    step();
    drive(0, 32'h10, NOP, 0, 7'd0, 0, 0);
    #2;
`ifdef GSHARE_XOR_HASH_EN
    chk("hash_idx", {25'd0, pred_idx}, 32'h01);
`else
    chk("hash_idx", {25'd0, pred_idx}, 32'h54);
`endif
    chk("stat_br13", stat_branches, 32'd13);
    chk("stat_mis4", stat_mispredicts, 32'd4);

    // Asynchronous reset mid-cycle.
    step();
    drive(1, 32'h1000, JAL, 0, 7'd0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_taken", {31'd0, pred_jump_or_not}, 32'd0);
    chk("arst_pc", pred_pc, 32'd0);
    chk("arst_idx", {25'd0, pred_idx}, 32'd0);
    chk("arst_br", stat_branches, 32'd0);
    chk("arst_mis", stat_mispredicts, 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("post_jal_taken", {31'd0, pred_jump_or_not}, 32'd1);
    chk("post_jal_pc", pred_pc, 32'h1100);
    drive(0, 32'h14, B16, 0, 7'd0, 0, 0);
    #1;
    chk("post_t5_taken", {31'd0, pred_jump_or_not}, 32'd1);
    chk("post_t5_pc", pred_pc, 32'h24);
    chk("post_t5_idx", {25'd0, pred_idx}, 32'd5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
